// File: rtl/exotiny_spi_master.sv
// -----------------------------------------------------------------------------
// exotiny_spi_master
//
// SPI master for the exotiny peripheral bus. It takes one word per valid/ready
// handshake and shifts it out on sdo while shifting the reply in from sdi. The
// word width, number of chip selects, clock divider, CPOL and CPHA are all
// configurable. A word sent with tx_last_i=0 keeps its chip select low, so the
// next word goes back to back under the same CS assertion.
//
// Optional feature (compile-time macro EXOTINY_SPI_LSB_FIRST_EN):
//   When the macro is defined, input cfg_lsb_first_i selects LSB-first order for
//   both tx and rx. It is latched with the rest of the config at the IDLE
//   handshake. rx_data_o always keeps the natural bit order. When the macro is
//   undefined the port does not exist and the order is always MSB first.
//
// Parameters:
//   DW      bits per word (4..32)
//   NUM_CS  number of active-low chip selects (1..8)
//   DIV_W   width of the divider config field
//   CSW     width of the CS select field (derived from NUM_CS)
//
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   cfg_div_i           half-period H = cfg_div_i + 1 clk cycles
//   cfg_cpol_i          SCK idle level
//   cfg_cpha_i          0: sample on leading edge, 1: sample on trailing edge
//   cs_sel_i            chip select index; values >= NUM_CS assert no line
//   tx_valid_i/ready_o  word handshake
//   tx_data_i           word to send
//   tx_last_i           release CS after this word
//   rx_valid_o          one-cycle pulse; rx_data_o is valid
//   rx_data_o           received word, held until the next word completes
//   busy_o              high whenever the engine is not in IDLE
//   spi_sck_o/sdo_o     serial clock and serial data out
//   spi_sdi_i           serial data in
//   spi_cs_on           chip selects, active low
// -----------------------------------------------------------------------------
module exotiny_spi_master #(
    parameter  int DW     = 8,
    parameter  int NUM_CS = 2,
    parameter  int DIV_W  = 8,
    localparam int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic              cfg_cpol_i,
    input  logic              cfg_cpha_i,
`ifdef EXOTINY_SPI_LSB_FIRST_EN
    input  logic              cfg_lsb_first_i,
`endif
    input  logic [CSW-1:0]    cs_sel_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DW-1:0]     tx_data_i,
    input  logic              tx_last_i,
    output logic              rx_valid_o,
    output logic [DW-1:0]     rx_data_o,
    output logic              busy_o,
    output logic              spi_sck_o,
    output logic              spi_sdo_o,
    input  logic              spi_sdi_i,
    output logic [NUM_CS-1:0] spi_cs_on
);

    // The edge counter must reach 2*DW. The half-period counter is one bit
    // wider than the divider, so an all-ones divider gives H = 2^DIV_W.
    localparam int             EW        = $clog2(2 * DW + 1);
    localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DW - 1);
    localparam logic [DIV_W:0] CNT_ONE   = (DIV_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W:0]    cnt_q;
    logic [EW-1:0]     edge_cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              last_q;
    logic [DW-1:0]     tx_sh_q;
    logic [DW-1:0]     rx_sh_q;
    logic [DW-1:0]     rx_data_q;
    logic              rx_valid_q;
    logic              tx_ready_q;
    logic              sck_q;
    logic              sdo_q;
    logic [NUM_CS-1:0] cs_n_q;

    logic              handshake;
    logic              half_done;
    logic              sck_edge;
    logic              final_edge;
    logic              odd_edge;
    logic              sample;
    logic              shift_out;
    logic [DW-1:0]     rx_sh_d;
    logic [DIV_W:0]    h_load;
    logic              cpha_eff;
    logic [DW-1:0]     tx_word;
    logic [DW-1:0]     rx_word;

    // A select value outside 0..NUM_CS-1 matches no line, so the word still
    // shifts out but no CS line goes low.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CSW'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

`ifdef EXOTINY_SPI_LSB_FIRST_EN
    logic lsb_q;
    logic lsb_eff;

    function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
        return r;
    endfunction

    // Reversing the word at both ends lets the shifters always work MSB first.
    assign lsb_eff = (state_q == ST_IDLE) ? cfg_lsb_first_i : lsb_q;
    assign tx_word = lsb_eff ? bit_rev(tx_data_i) : tx_data_i;
    assign rx_word = lsb_q ? bit_rev(rx_sh_d) : rx_sh_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lsb_q <= 1'b0;
        end else if (state_q == ST_IDLE && handshake) begin
            lsb_q <= cfg_lsb_first_i;
        end
    end
`else
    assign tx_word = tx_data_i;
    assign rx_word = rx_sh_d;
`endif

    // At the IDLE handshake the config is being latched on the same edge, so
    // use the live inputs. In WAIT, use the values latched for this CS frame.
    assign cpha_eff = (state_q == ST_IDLE) ? cfg_cpha_i : cpha_q;
    assign h_load   = ((state_q == ST_IDLE) ? {1'b0, cfg_div_i} : {1'b0, div_q}) + CNT_ONE;
    assign odd_edge = ~edge_cnt_q[0];   // edge_cnt_q counts the edges already done

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        handshake  = tx_valid_i && tx_ready_q;
        half_done  = (cnt_q == CNT_ONE);
        sck_edge   = 1'b0;
        final_edge = 1'b0;
        sample     = 1'b0;
        shift_out  = 1'b0;

        if (state_q == ST_SHIFT && half_done) begin
            sck_edge   = 1'b1;
            final_edge = (edge_cnt_q == LAST_EDGE);
            // CPHA=0 samples on odd edges and shifts on even edges. CPHA=1 is
            // the other way round. CPHA=0 skips the shift after the final edge
            // so sdo keeps showing the last bit.
            sample     = odd_edge ^ cpha_q;
            shift_out  = cpha_q ? odd_edge : (~odd_edge && ~final_edge);
        end

        rx_sh_d = sample ? {rx_sh_q[DW-2:0], spi_sdi_i} : rx_sh_q;

        case (state_q)
            ST_IDLE:    if (handshake)               state_d = ST_SETUP;
            ST_SETUP:   if (half_done)               state_d = ST_SHIFT;
            ST_SHIFT:   if (final_edge)              state_d = ST_HOLD;
            ST_HOLD:    if (half_done)               state_d = last_q ? ST_RELEASE : ST_WAIT;
            ST_WAIT:    if (handshake)               state_d = ST_SHIFT;
            ST_RELEASE: if (half_done)               state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    // NOTE: state elements use non-blocking assignments only, so every
    // right-hand side here reads the pre-edge value no matter the statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            last_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            sck_q      <= 1'b0;
            sdo_q      <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            rx_valid_q <= final_edge;
            tx_ready_q <= (state_d == ST_IDLE) || (state_d == ST_WAIT);
            rx_sh_q    <= rx_sh_d;

            // Reload the half-period counter on every state change and every
            // SCK edge. Each timed interval therefore lasts exactly H cycles.
            if (state_d != state_q || sck_edge) begin
                cnt_q <= h_load;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_ONE;
            end

            if (state_q == ST_IDLE) begin
                sck_q <= cfg_cpol_i;
                if (handshake) begin
                    div_q  <= cfg_div_i;
                    cpol_q <= cfg_cpol_i;
                    cpha_q <= cfg_cpha_i;
                    cs_n_q <= cs_decode(cs_sel_i);
                end
            end else if (sck_edge) begin
                sck_q <= ~sck_q;
            end

            if (handshake) begin
                last_q     <= tx_last_i;
                edge_cnt_q <= '0;
                if (!cpha_eff) begin
                    // CPHA=0: the first bit must be on sdo before the first edge.
                    sdo_q   <= tx_word[DW-1];
                    tx_sh_q <= {tx_word[DW-2:0], 1'b0};
                end else begin
                    tx_sh_q <= tx_word;
                end
            end else begin
                if (shift_out) begin
                    sdo_q   <= tx_sh_q[DW-1];
                    tx_sh_q <= {tx_sh_q[DW-2:0], 1'b0};
                end
                if (sck_edge) begin
                    edge_cnt_q <= edge_cnt_q + EW'(1);
                end
            end

            // Include the bit sampled on this same edge (CPHA=1 samples on the final edge).
            if (final_edge) begin
                rx_data_q <= rx_word;
            end

            if (state_d == ST_RELEASE && state_q != ST_RELEASE) begin
                cs_n_q <= '1;
                sdo_q  <= 1'b0;
                sck_q  <= cpol_q;
            end
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign spi_sck_o  = sck_q;
    assign spi_sdo_o  = sdo_q;
    assign spi_cs_on  = cs_n_q;

endmodule

// File: tb/tb_exotiny_spi_master.sv
// -----------------------------------------------------------------------------
// tb_exotiny_spi_master
//
// Self-checking bench for exotiny_spi_master. One instance uses the default
// parameters. A second instance with NUM_CS=3 is there because cs_sel=3 is only
// reachable when the select field is two bits wide. Expected rx words go into a
// scoreboard queue when a word is sent. A monitor pops and compares them on
// each rx_valid pulse. The same monitor also counts SCK edges, edge spacing,
// CS-low cycles and the relevant event cycles.
// -----------------------------------------------------------------------------
module tb_exotiny_spi_master;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] cfg_div;
    logic       cfg_cpol;
    logic       cfg_cpha;
    logic [7:0] tx_data;
    logic       tx_last;

    logic [0:0] cs_sel;
    logic       tx_valid, tx_ready, rx_valid, busy, sck, sdo, sdi;
    logic [7:0] rx_data;
    logic [1:0] cs;

    logic [1:0] cs_sel3;
    logic       tx_valid3, tx_ready3, rx_valid3, busy3, sck3, sdo3;
    logic [7:0] rx_data3;
    logic [2:0] cs3;

    exotiny_spi_master u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_div_i  (cfg_div),
        .cfg_cpol_i (cfg_cpol),
        .cfg_cpha_i (cfg_cpha),
        .cs_sel_i   (cs_sel),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_data_i  (tx_data),
        .tx_last_i  (tx_last),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .busy_o     (busy),
        .spi_sck_o  (sck),
        .spi_sdo_o  (sdo),
        .spi_sdi_i  (sdi),
        .spi_cs_on  (cs)
    );

    exotiny_spi_master #(.NUM_CS(3)) u_dut3 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_div_i  (cfg_div),
        .cfg_cpol_i (cfg_cpol),
        .cfg_cpha_i (cfg_cpha),
        .cs_sel_i   (cs_sel3),
        .tx_valid_i (tx_valid3),
        .tx_ready_o (tx_ready3),
        .tx_data_i  (tx_data),
        .tx_last_i  (tx_last),
        .rx_valid_o (rx_valid3),
        .rx_data_o  (rx_data3),
        .busy_o     (busy3),
        .spi_sck_o  (sck3),
        .spi_sdo_o  (sdo3),
        .spi_sdi_i  (sdo3),
        .spi_cs_on  (cs3)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard of expected rx words.
    logic [7:0] exp_q[$];

    // Slave model. In loopback mode sdi mirrors sdo. In slave mode it returns
    // slave_word MSB first: for CPHA=1, bit k goes out on leading edge 2k+1.
    logic       slave_mode;
    logic [7:0] slave_word;

    // Monitor counters, sampled on the falling clock edge.
    int         cyc, edges, last_edge, min_iv, max_iv, iv;
    int         sdo_chg, sdo_bad, cs_low, cs_hit, cs_rise, cs_rise_cyc, busy_fall_cyc;
    int         rx_cnt, rx_last_cyc;
    int         edges3, cs3_low, rx3_cnt;
    logic [1:0] exp_cs, cs_prev;
    logic       sck_prev, sdo_prev, busy_prev, sck3_prev;

    always_comb begin
        sdi = sdo;
        if (slave_mode) begin
            if (edges <= 1) sdi = slave_word[7];
            else            sdi = slave_word[3'(7 - (edges - 1) / 2)];
        end
    end

    always @(negedge clk_i) begin
        cyc++;
        if (busy && sck != sck_prev) begin
            if (edges > 0) begin
                iv = cyc - last_edge;
                if (iv < min_iv) min_iv = iv;
                if (iv > max_iv) max_iv = iv;
            end
            edges++;
            last_edge = cyc;
        end
        if (busy && sdo != sdo_prev) begin
            sdo_chg++;
            if (!(sck_prev == 1'b1 && sck == 1'b0)) sdo_bad++;
        end
        if (cs != 2'b11) cs_low++;
        if (cs == exp_cs) cs_hit++;
        if (cs == 2'b11 && cs_prev != 2'b11) begin
            cs_rise++;
            cs_rise_cyc = cyc;
        end
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        if (rx_valid) begin
            rx_cnt++;
            rx_last_cyc = cyc;
            check("sb_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
        end
        if (busy3 && sck3 != sck3_prev) edges3++;
        if (cs3 != 3'b111) cs3_low++;
        if (rx_valid3) begin
            rx3_cnt++;
            check("sb_pending3", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rx_data3", rx_data3, exp_q.pop_front());
        end
        sck_prev  = sck;
        sdo_prev  = sdo;
        cs_prev   = cs;
        busy_prev = busy;
        sck3_prev = sck3;
    end

    task automatic clear_mon(input logic [1:0] cs_expect);
        edges = 0; last_edge = 0; min_iv = 1 << 30; max_iv = 0;
        sdo_chg = 0; sdo_bad = 0; cs_low = 0; cs_hit = 0; cs_rise = 0;
        cs_rise_cyc = 0; busy_fall_cyc = 0; rx_cnt = 0; rx_last_cyc = 0;
        edges3 = 0; cs3_low = 0; rx3_cnt = 0;
        exp_cs = cs_expect;
        sck_prev = sck; sdo_prev = sdo; cs_prev = cs; busy_prev = busy; sck3_prev = sck3;
    endtask

    // Offer one word and return just after the handshake edge. valid stays
    // high unless this is the last word, so bursts run back to back.
    task automatic send(input logic [7:0] d, input logic last, input logic [7:0] exp_rx,
                        input bit to3);
        bit got;
        tx_data = d;
        tx_last = last;
        if (to3) tx_valid3 = 1'b1; else tx_valid = 1'b1;
        exp_q.push_back(exp_rx);
        got = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (to3 ? tx_ready3 : tx_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!got) check("hs_timeout", 32'(to3 ? tx_ready3 : tx_ready), 1);
        @(posedge clk_i);
        #1;
        if (last || !got) begin
            tx_valid  = 1'b0;
            tx_valid3 = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit to3);
        int n;
        n = 0;
        while ((to3 ? busy3 : busy) && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        if (to3 ? busy3 : busy) check("idle_timeout", 32'(to3 ? busy3 : busy), 0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    int rx_before;
    int k;

    initial begin
        cfg_div = 8'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        tx_data = 8'h00; tx_last = 1'b0;
        cs_sel = 1'b0; tx_valid = 1'b0;
        cs_sel3 = 2'd0; tx_valid3 = 1'b0;
        slave_mode = 1'b0; slave_word = 8'h00;
        cyc = 0;
        clear_mon(2'b00);

        // Reset values.
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        #2;
        check("rst_cs", cs, 2'b11);
        check("rst_sck", sck, 0);
        check("rst_sdo", sdo, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("idle_ready", tx_ready, 1);

        // Mode 0, H=2, cs_sel=1, 0xA5 with loopback.
        clear_mon(2'b01);
        cs_sel = 1'b1;
        send(8'hA5, 1'b1, 8'hA5, 1'b0);
        wait_idle(1'b0);
        check("m0_cs_hit", cs_hit, 36);
        check("m0_cs_low", cs_low, 36);
        check("m0_edges", edges, 16);
        check("m0_iv_min", min_iv, 2);
        check("m0_iv_max", max_iv, 2);
        check("m0_rx_cnt", rx_cnt, 1);
        check("m0_busy_after_cs", busy_fall_cyc - cs_rise_cyc, 2);

        // Mode 3, H=1, 0x3C out, slave returns 0xC3.
        cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_div = 8'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("m3_sck_idle", sck, 1);
        clear_mon(2'b10);
        slave_word = 8'hC3;
        slave_mode = 1'b1;
        cs_sel = 1'b0;
        send(8'h3C, 1'b1, 8'hC3, 1'b0);
        wait_idle(1'b0);
        slave_mode = 1'b0;
        check("m3_edges", edges, 16);
        check("m3_sdo_changes", sdo_chg, 2);
        check("m3_sdo_not_falling", sdo_bad, 0);
        check("m3_rx_cnt", rx_cnt, 1);
        check("m3_sck_end", sck, 1);

        // Burst of three words under one CS assertion, mode 0, H=1.
        cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        clear_mon(2'b10);
        send(8'h01, 1'b0, 8'h01, 1'b0);
        send(8'h02, 1'b0, 8'h02, 1'b0);
        send(8'h03, 1'b1, 8'h03, 1'b0);
        wait_idle(1'b0);
        check("burst_cs_low", cs_low, 54);
        check("burst_cs_hit", cs_hit, 54);
        check("burst_cs_rise", cs_rise, 1);
        check("burst_rx_cnt", rx_cnt, 3);
        check("burst_cs_after_hold", cs_rise_cyc - rx_last_cyc, 1);

        // cs_sel=3 on the three-CS instance: no CS line ever goes low.
        clear_mon(2'b00);
        cs_sel3 = 2'd3;
        send(8'h5A, 1'b1, 8'h5A, 1'b1);
        wait_idle(1'b1);
        check("nocs_cs_low", cs3_low, 0);
        check("nocs_edges", edges3, 16);
        check("nocs_rx_cnt", rx3_cnt, 1);

        // Reset during SHIFT after the 7th SCK edge.
        cfg_div = 8'd1;
        clear_mon(2'b01);
        cs_sel = 1'b1;
        send(8'h96, 1'b1, 8'h96, 1'b0);
        k = 0;
        while (edges < 7 && k < 500) begin
            @(negedge clk_i);
            k++;
        end
        check("rst_mid_reached_edge7", edges, 7);
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_cs", cs, 2'b11);
        check("rst_mid_sck", sck, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", tx_ready, 0);
        check("rst_mid_rx_valid", rx_valid, 0);
        exp_q.delete();
        rx_before = rx_cnt;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1;
        check("rst_mid_no_rx", rx_cnt, rx_before);
        check("rst_mid_stays_idle", busy, 0);

        clear_mon(2'b01);
        send(8'h69, 1'b1, 8'h69, 1'b0);
        wait_idle(1'b0);
        check("rst_fresh_cs_low", cs_low, 36);
        check("rst_fresh_rx_cnt", rx_cnt, 1);

        // Maximum divider: H = 256 with no wrap.
        cfg_div = 8'hFF;
        clear_mon(2'b10);
        cs_sel = 1'b0;
        send(8'h81, 1'b1, 8'h81, 1'b0);
        wait_idle(1'b0);
        check("divmax_iv_min", min_iv, 256);
        check("divmax_iv_max", max_iv, 256);
        check("divmax_edges", edges, 16);
        check("divmax_cs_low", cs_low, 18 * 256);
        check("divmax_rx_cnt", rx_cnt, 1);

        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
